// File: rtl/mapper_ram_arbiter.sv
// Shares one byte-wide memory port between the mapped CPU and the loader.
// The CPU wins by default; the loader is guaranteed a slot after CPU_MAX
// consecutive CPU grants while it waits.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no access in flight; arbitrate between CPU and loader
// CPU_ACC | CPU access issued on the memory port, waiting for mem_ack
// LD_ACC  | loader write issued on the memory port, waiting for mem_ack
module mapper_ram_arbiter #(
  parameter int ADDR_W  = 27,
  parameter int CPU_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_wait,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, CPU_ACC, LD_ACC} state_t;

  localparam logic [3:0] GNT_MAX = 4'(CPU_MAX);

  state_t              state_q, state_d;
  logic                cpu_pending;
  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_wr;
  logic [7:0]          lat_din;
  logic [3:0]          gnt_cnt;
  logic                grant_cpu, grant_ld;
  logic                cpu_done, ld_done;
  logic                cpu_accept, cpu_any;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_wr;
  logic [7:0]          sel_din;

  assign cpu_done   = (state_q == CPU_ACC) && mem_ack;
  assign ld_done    = (state_q == LD_ACC) && mem_ack;
  // A strobe landing on the completing edge of the previous CPU access is
  // accepted, so set wins over clear and the CPU never sees wait drop.
  assign cpu_accept = cpu_req && (!cpu_pending || cpu_done);
  assign cpu_wait   = cpu_req | cpu_pending;
  // A strobe arriving in IDLE competes immediately, using the raw inputs,
  // so the CPU wins a same-cycle tie with the loader.
  assign cpu_any    = cpu_pending | cpu_req;
  assign sel_addr   = cpu_pending ? lat_addr : cpu_addr;
  assign sel_wr     = cpu_pending ? lat_wr   : cpu_wr;
  assign sel_din    = cpu_pending ? lat_din  : cpu_din;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Arbitration and next-state decode.
  always_comb begin
    state_d   = state_q;
    grant_cpu = 1'b0;
    grant_ld  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_any && !(ld_req && (gnt_cnt == GNT_MAX))) begin
          grant_cpu = 1'b1;
          state_d   = CPU_ACC;
        end else if (ld_req) begin
          grant_ld = 1'b1;
          state_d  = LD_ACC;
        end
      end
      CPU_ACC: if (mem_ack) state_d = IDLE;
      LD_ACC:  if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // CPU request capture: pending flag plus the access attributes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_pending <= 1'b0;
      lat_addr    <= '0;
      lat_wr      <= 1'b0;
      lat_din     <= 8'h00;
    end else if (cpu_accept) begin
      cpu_pending <= 1'b1;
      lat_addr    <= cpu_addr;
      lat_wr      <= cpu_wr;
      lat_din     <= cpu_din;
    end else if (cpu_done) begin
      cpu_pending <= 1'b0;
    end
  end

  // Consecutive CPU grants while the loader waits; saturates at CPU_MAX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  gnt_cnt <= 4'd0;
    else if (grant_ld || !ld_req)  gnt_cnt <= 4'd0;
    else if (grant_cpu && (gnt_cnt != GNT_MAX)) gnt_cnt <= gnt_cnt + 4'd1;
  end

  // Memory port: registered request, held stable until mem_ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
    end else if (grant_cpu) begin
      mem_req   <= 1'b1;
      mem_we    <= sel_wr;
      mem_addr  <= sel_addr;
      mem_wdata <= sel_din;
    end else if (grant_ld) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b1;
      mem_addr  <= ld_addr;
      mem_wdata <= ld_data;
    end else if (cpu_done || ld_done) begin
      mem_req   <= 1'b0;
    end
  end

  // Completion: loader ack pulse and CPU read data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_ack   <= 1'b0;
      cpu_dout <= 8'hFF;
    end else begin
      ld_ack <= ld_done;
      if (cpu_done && !mem_we) cpu_dout <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mapper_ram_arbiter.sv
// Bench for mapper_ram_arbiter: memory model, loader driver, and a monitor
// that scores every memory transaction and CPU read against queued
// expectations pushed by the directed tests.
module tb_mapper_ram_arbiter;
  localparam int AW = 27;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } txn_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } ldw_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_wr;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_dout;
  logic          cpu_wait;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  logic          ld_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          mem_ack;

  int checks   = 0;
  int failures = 0;

  txn_t       exp_q[$];
  logic [7:0] exp_dout_q[$];
  ldw_t       ld_q[$];
  logic [7:0] mem [logic [AW-1:0]];

  int   ack_delay = 0;
  int   wait_cnt  = 0;
  bit   stale_ack = 1'b0;
  bit   req_prev  = 1'b0;
  bit   dout_due  = 1'b0;
  int   ld_ack_cnt = 0;
  txn_t mon_e;

  int n, k, base;
  bit dropped, sent;

  always #5 clk = ~clk;

  mapper_ram_arbiter #(.ADDR_W(AW), .CPU_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (t < 300 && !(exp_q.size() == 0 && ld_q.size() == 0 && !mem_req &&
                        !cpu_wait && !mem_ack)) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_idle_reached"}, 64'(t < 300), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  // Memory model: acks each request after ack_delay cycles; stale_ack
  // injects a single unsolicited ack pulse.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (stale_ack) begin
        mem_ack   = 1'b1;
        stale_ack = 1'b0;
      end else if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
          if (mem_we) mem[mem_addr] = mem_wdata;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Loader: presents the head of ld_q, advances on ld_ack.
  initial begin
    ld_req  = 1'b0;
    ld_addr = '0;
    ld_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (ld_ack && ld_q.size() > 0) void'(ld_q.pop_front());
      if (ld_q.size() > 0) begin
        ld_req  = 1'b1;
        ld_addr = ld_q[0].a;
        ld_data = ld_q[0].d;
      end else begin
        ld_req = 1'b0;
      end
    end
  end

  // Monitor: scores each new memory request and each completed CPU read.
  initial begin
    forever begin
      @(negedge clk);
      if (dout_due) begin
        dout_due = 1'b0;
        if (exp_dout_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL cpu_dout_unexpected: got 0x%0h, want no read", cpu_dout);
        end else begin
          chk("cpu_dout", 64'(cpu_dout), 64'(exp_dout_q.pop_front()));
        end
      end
      if (reset_n && mem_req && mem_ack && !mem_we) dout_due = 1'b1;
      if (mem_req && !req_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mem_txn_unexpected: got we=%0b addr=0x%0h data=0x%0h, want none",
                   mem_we, mem_addr, mem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("mem_txn", 64'({mem_we, mem_addr, mem_wdata}), 64'(mon_e));
        end
      end
      req_prev = mem_req;
      if (ld_ack) ld_ack_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  // Directed tests.
  initial begin
    reset_n  = 1'b0;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    cpu_wr   = 1'b0;
    cpu_din  = 8'h00;
    mem[27'h0004123] = 8'h5A;
    mem[27'h0000300] = 8'hC3;
    mem[27'h0000400] = 8'h77;
    mem[27'h0000500] = 8'h5C;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_mem_req",   64'(mem_req),   64'd0);
    chk("rst_mem_we",    64'(mem_we),    64'd0);
    chk("rst_mem_addr",  64'(mem_addr),  64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_cpu_dout",  64'(cpu_dout),  64'hFF);
    chk("rst_ld_ack",    64'(ld_ack),    64'd0);
    chk("rst_cpu_wait0", 64'(cpu_wait),  64'd0);
    cpu_req = 1'b1; #1;
    chk("rst_cpu_wait1", 64'(cpu_wait),  64'd1);
    cpu_req = 1'b0; #1;
    chk("rst_cpu_wait2", 64'(cpu_wait),  64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // CPU read with slow memory.
    exp_q.push_back({1'b0, 27'h0004123, 8'h00});
    exp_dout_q.push_back(8'h5A);
    ack_delay = 2;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = 27'h0004123; cpu_wr = 1'b0; cpu_din = 8'h00;
    @(negedge clk);
    chk("read_strobe_wait", 64'(cpu_wait), 64'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    n = 0;
    while (n < 40 && !(mem_ack && mem_req)) begin
      @(negedge clk);
      n++;
    end
    chk("read_ack_seen", 64'(n < 40), 64'd1);
    @(negedge clk);
    chk("read_wait_after_ack", 64'(cpu_wait), 64'd0);
    chk("read_dout", 64'(cpu_dout), 64'h5A);
    wait_idle("read");

    // Loader stream of three words.
    ack_delay = 0;
    base = ld_ack_cnt;
    exp_q.push_back({1'b1, 27'h0000000, 8'h11});
    exp_q.push_back({1'b1, 27'h0000001, 8'h22});
    exp_q.push_back({1'b1, 27'h0000002, 8'h33});
    ld_q.push_back({27'h0000000, 8'h11});
    ld_q.push_back({27'h0000001, 8'h22});
    ld_q.push_back({27'h0000002, 8'h33});
    wait_idle("ld_stream");
    chk("ld_stream_acks", 64'(ld_ack_cnt - base), 64'd3);

    // Simultaneous first request: CPU first, then loader.
    base = ld_ack_cnt;
    exp_q.push_back({1'b0, 27'h0000300, 8'h00});
    exp_q.push_back({1'b1, 27'h0000301, 8'h44});
    exp_dout_q.push_back(8'hC3);
    @(posedge clk);
    ld_q.push_back({27'h0000301, 8'h44});
    #1;
    cpu_req = 1'b1; cpu_addr = 27'h0000300; cpu_wr = 1'b0; cpu_din = 8'h00;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    wait_idle("simul");
    chk("simul_acks", 64'(ld_ack_cnt - base), 64'd1);

    // Set beats clear: second strobe on the first access's ack cycle.
    ack_delay = 1;
    exp_q.push_back({1'b0, 27'h0000400, 8'h00});
    exp_q.push_back({1'b1, 27'h0000401, 8'h99});
    exp_dout_q.push_back(8'h77);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = 27'h0000400; cpu_wr = 1'b0; cpu_din = 8'h00;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    dropped = 1'b0;
    sent    = 1'b0;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (!cpu_wait) dropped = 1'b1;
      if (mem_req && mem_we) break;
      if (sent) cpu_req = 1'b0;
      if (!sent && mem_req && mem_ack) begin
        cpu_req = 1'b1; cpu_addr = 27'h0000401; cpu_wr = 1'b1; cpu_din = 8'h99;
        sent = 1'b1;
      end
    end
    cpu_req = 1'b0;
    chk("sbc_second_issued", 64'(n < 60), 64'd1);
    chk("sbc_wait_no_drop", 64'(dropped), 64'd0);
    wait_idle("sbc");
    chk("dout_hold_write", 64'(cpu_dout), 64'h77);

    // Contention: C,C,C,C,L,C,C,C,C,L then one trailing C.
    ack_delay = 0;
    base = ld_ack_cnt;
    for (int g = 0; g < 11; g++) begin
      if (g == 4)       exp_q.push_back({1'b1, 27'h0000600, 8'hA1});
      else if (g == 9)  exp_q.push_back({1'b1, 27'h0000601, 8'hA2});
      else begin
        exp_q.push_back({1'b0, 27'h0000500, 8'h00});
        exp_dout_q.push_back(8'h5C);
      end
    end
    @(posedge clk);
    ld_q.push_back({27'h0000600, 8'hA1});
    ld_q.push_back({27'h0000601, 8'hA2});
    #1;
    cpu_req = 1'b1; cpu_addr = 27'h0000500; cpu_wr = 1'b0; cpu_din = 8'h00;
    n = 0;
    k = 0;
    while (n < 200 && k < 2) begin
      @(posedge clk); #1;
      n++;
      if (ld_ack) k++;
    end
    cpu_req = 1'b0;
    chk("cont_ld_acks_seen", 64'(k), 64'd2);
    wait_idle("cont");
    chk("cont_ld_ack_count", 64'(ld_ack_cnt - base), 64'd2);

    // Reset in the middle of a loader access.
    ack_delay = 30;
    base = ld_ack_cnt;
    exp_q.push_back({1'b1, 27'h0000700, 8'hB7});
    exp_q.push_back({1'b1, 27'h0000700, 8'hB7});
    ld_q.push_back({27'h0000700, 8'hB7});
    n = 0;
    while (n < 20 && !mem_req) begin
      @(negedge clk);
      n++;
    end
    chk("rld_granted", 64'(mem_req), 64'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rld_mem_req_async", 64'(mem_req),  64'd0);
    chk("rld_mem_addr_async", 64'(mem_addr), 64'd0);
    @(negedge clk);
    stale_ack = 1'b1;
    ack_delay = 3;
    @(negedge clk);
    reset_n = 1'b1;
    wait_idle("rld");
    chk("rld_ld_ack_count", 64'(ld_ack_cnt - base), 64'd1);
    chk("rld_cpu_dout", 64'(cpu_dout), 64'hFF);

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("exp_dout_drained", 64'(exp_dout_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mapper_ram_arbiter.md
MAPPER_RAM_ARBITER -- requirements
Module: mapper_ram_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 27, width of every memory address.
REQ-002 Parameter: CPU_MAX, default 4, max consecutive CPU grants while a loader request waits; legal range 1..15.
REQ-003 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: cpu_req  input  1  single-cycle strobe; a mapped CPU access starts.
REQ-006 Port: cpu_addr  input  ADDR_W  mapper-translated address; sampled with cpu_req.
REQ-007 Port: cpu_wr  input  1  1 = write, 0 = read; sampled with cpu_req.
REQ-008 Port: cpu_din  input  8  CPU write data; sampled with cpu_req.
REQ-009 Port: cpu_dout  output  8  read data of the last completed CPU read.
REQ-010 Port: cpu_wait  output  1  CPU wait; high while a CPU access is pending or being served.
REQ-011 Port: ld_req  input  1  loader write request, level; held until ld_ack.
REQ-012 Port: ld_addr  input  ADDR_W  loader write address; stable while ld_req is high.
REQ-013 Port: ld_data  input  8  loader write data; stable while ld_req is high.
REQ-014 Port: ld_ack  output  1  one-cycle pulse; loader write completed.
REQ-015 Port: mem_req  output  1  memory request; held until mem_ack.
REQ-016 Port: mem_we  output  1  memory write enable, valid with mem_req.
REQ-017 Port: mem_addr  output  ADDR_W  memory address, valid with mem_req.
REQ-018 Port: mem_wdata  output  8  memory write data, valid with mem_req.
REQ-019 Port: mem_rdata  input  8  memory read data, valid in the mem_ack cycle.
REQ-020 Port: mem_ack  input  1  one-cycle completion of the current mem_req.

Function
REQ-021 FSM states: IDLE, CPU_ACC, LD_ACC.
REQ-022 cpu_req sets a cpu_pending flag and latches cpu_addr/cpu_wr/cpu_din on that edge; cpu_req while cpu_pending is set is ignored.
REQ-023 cpu_wait = cpu_req OR cpu_pending (combinational), so wait rises in the strobe cycle.
REQ-024 IDLE arbitration: cpu_pending only -> CPU_ACC; ld_req only -> LD_ACC; both -> CPU_ACC unless the grant counter equals CPU_MAX, then LD_ACC.
REQ-025 Grant counter: +1 on each CPU grant made while ld_req is high; cleared on each loader grant and whenever ld_req is low; saturates at CPU_MAX.
REQ-026 On entry to CPU_ACC/LD_ACC, mem_req and the selected addr/we/wdata are registered outputs; they are stable until mem_ack.
REQ-027 mem_ack in CPU_ACC: on a read, cpu_dout <= mem_rdata; cpu_pending cleared; next state IDLE.
REQ-028 mem_ack in LD_ACC: ld_ack pulses high for exactly the next cycle; next state IDLE.
REQ-029 mem_req drops in the cycle after mem_ack; a new grant is made from IDLE at the earliest one cycle later, giving minimum access spacing of 2 cycles idle-to-idle.
REQ-030 cpu_req in the same cycle as mem_ack ending a CPU access: set beats clear, so a new access is pending and cpu_wait stays high.
REQ-031 Loader must hold ld_req until ld_ack; after ld_ack, it drops ld_req or presents the next word; ld_req low during LD_ACC does not abort the access.
REQ-032 mem_ack outside CPU_ACC/LD_ACC is ignored.
REQ-033 cpu_dout holds its value across writes and idle cycles.

Reset
REQ-034 reset_n low asynchronously forces: state IDLE; cpu_pending 0; grant counter 0; mem_req 0; mem_we 0; mem_addr 0; mem_wdata 0; cpu_dout 8'hFF; ld_ack 0; cpu_wait follows cpu_req only.
REQ-035 Reset during CPU_ACC or LD_ACC abandons the access with no ld_ack and no cpu_dout update; a mem_ack after release is ignored per REQ-032.

Verification
REQ-036 CPU read: cpu_req with addr 0x0004123, wr=0; mem_ack after 3 cycles with rdata 0x5A -> mem_req=1, addr 0x0004123, we=0; cpu_dout=0x5A; cpu_wait low the cycle after mem_ack.
REQ-037 Loader stream: 3 words to 0x0000000..0x0000002 (0x11, 0x22, 0x33), mem_ack 1 cycle after each mem_req -> 3 writes in order, 3 ld_ack pulses, we=1.
REQ-038 Contention, CPU_MAX=4: ld_req held high plus back-to-back CPU reads -> grant order C,C,C,C,L,C,C,C,C,L; no loader starvation.
REQ-039 Simultaneous first request: cpu_req and ld_req in the same IDLE cycle with counter 0 -> CPU granted first, loader next.
REQ-040 Set-beats-clear: cpu_req coincident with mem_ack of prior CPU access -> second access issued; cpu_wait never drops between them.
REQ-041 Reset mid-LD_ACC: reset_n low while mem_req=1 -> mem_req 0 immediately; after release with ld_req high -> fresh LD_ACC grant, stale mem_ack ignored, exactly one ld_ack.
